// File: rtl/dm_wait.sv
// Data memory for the MEM stage: byte/half/word access with byte-merge stores, extending loads,
// alignment/range exceptions and a configurable wait-state latency behind a req/ready/done handshake.
module dm_wait #(
    parameter int unsigned DEPTH   = 3072,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  dm_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] wpc_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        exc_adel_o,
    output logic        exc_ades_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q;
    logic [IW-1:0]  clr_q;
    logic [3:0]     cnt_q;
    logic           we_q;
    logic [2:0]     op_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    wpc_q;
    logic [IW-1:0]  idx_q;
    logic           ready_q;
    logic           done_q;
    logic [31:0]    rdata_q;
    logic           adel_q;
    logic           ades_q;

    logic [31:0]    mem [DEPTH];

    logic [31:0]    idx_full;
    logic           bad_op;
    logic           misalign;
    logic           out_of_range;
    logic           req_exc;
    logic           access;
    logic [31:0]    old_word;
    logic [31:0]    lane_word;
    logic [31:0]    merged_d;
    logic [31:0]    load_d;
    logic           mem_we;
    logic [IW-1:0]  mem_widx;
    logic [31:0]    mem_wdat;

    // Index computed on full 32 bits so out-of-range addresses never alias into the array.
    assign idx_full     = {2'b00, addr_i[31:2]} - {2'b00, BASE[31:2]};
    assign bad_op       = (dm_op_i > 3'd4);
    assign out_of_range = (addr_i < BASE) || (idx_full >= 32'(DEPTH));

    always_comb begin
        misalign = 1'b0;
        case (dm_op_i)
            3'd0:       misalign = (addr_i[1:0] != 2'b00);
            3'd1, 3'd2: misalign = addr_i[0];
            default:    misalign = 1'b0;
        endcase
    end

    assign req_exc   = bad_op || misalign || out_of_range;
    assign access    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign old_word  = mem[idx_q];
    assign lane_word = old_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        merged_d = old_word;
        load_d   = old_word;
        case (op_q)
            3'd1, 3'd2: begin
                if (addr_q[1]) merged_d[31:16] = wdata_q[15:0];
                else           merged_d[15:0]  = wdata_q[15:0];
                load_d = (op_q == 3'd1) ? {{16{lane_word[15]}}, lane_word[15:0]}
                                        : {16'h0000, lane_word[15:0]};
            end
            3'd3, 3'd4: begin
                case (addr_q[1:0])
                    2'd0:    merged_d[7:0]   = wdata_q[7:0];
                    2'd1:    merged_d[15:8]  = wdata_q[7:0];
                    2'd2:    merged_d[23:16] = wdata_q[7:0];
                    default: merged_d[31:24] = wdata_q[7:0];
                endcase
                load_d = (op_q == 3'd3) ? {{24{lane_word[7]}}, lane_word[7:0]}
                                        : {24'h000000, lane_word[7:0]};
            end
            default: begin
                merged_d = wdata_q;
                load_d   = old_word;
            end
        endcase
    end

    assign mem_we   = (state_q == S_INIT) || (access && we_q);
    assign mem_widx = (state_q == S_INIT) ? clr_q : idx_q;
    assign mem_wdat = (state_q == S_INIT) ? '0 : merged_d;

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_widx] <= mem_wdat;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (access && we_q)
            $display("@%h: *%h <= %h", wpc_q, {addr_q[31:2], 2'b00}, merged_d);
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            clr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wpc_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == IW'(DEPTH - 1)) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        op_q    <= dm_op_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        wpc_q   <= wpc_i;
                        rdata_q <= '0;
                        ready_q <= 1'b0;
                        if (req_exc) begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            adel_q  <= ~we_i;
                            ades_q  <= we_i;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(LATENCY);
                            idx_q   <= idx_full[IW-1:0];
                            adel_q  <= 1'b0;
                            ades_q  <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_RESP;
                        done_q  <= 1'b1;
                        if (!we_q) rdata_q <= load_d;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign done_o     = done_q;
    assign rdata_o    = rdata_q;
    assign exc_adel_o = adel_q;
    assign exc_ades_o = ades_q;

endmodule

// File: tb/tb_dm_wait.sv
// Scoreboard bench for dm_wait: driver pushes hand-computed responses, a monitor pops them on done.
module tb_dm_wait;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 2;

    typedef struct {
        string        name;
        logic [31:0]  rdata;
        logic         adel;
        logic         ades;
        int unsigned  due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wpc;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned dones  = 0;
    exp_t        sb[$];

    dm_wait #(.DEPTH(DEPTH), .BASE(32'h0000_0000), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .dm_op_i(op),
        .addr_i(addr), .wdata_i(wdata), .wpc_i(wpc), .ready_o(ready), .done_o(done),
        .rdata_o(rdata), .exc_adel_o(adel), .exc_ades_o(ades)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no response pending", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_rdata"}, rdata, e.rdata);
                check({e.name, "_adel"}, 32'(adel), 32'(e.adel));
                check({e.name, "_ades"}, 32'(ades), 32'(e.ades));
                check({e.name, "_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 200 cycles", ready);
        end
    endtask

    task automatic issue(input string nm, input logic w, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic xl, input logic xs);
        exp_t e;
        wait_ready();
        req = 1'b1; we = w; op = o; addr = a; wdata = d; wpc = 32'h0000_1000 + a;
        e.name  = nm;
        e.rdata = exp_rd;
        e.adel  = xl;
        e.ades  = xs;
        e.due   = cyc + 1 + ((xl || xs) ? 0 : LAT + 1);
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic reset_and_init(input string nm);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check({nm, "_rst_ready"}, 32'(ready), 32'd0);
        check({nm, "_rst_done"},  32'(done),  32'd0);
        check({nm, "_rst_rdata"}, rdata, 32'h0);
        check({nm, "_rst_exc"},   32'({adel, ades}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check({nm, "_init_ready_low"}, 32'(ready), 32'd0);
            @(negedge clk);
        end
        check({nm, "_init_ready_high"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int unsigned accepts;
        int unsigned dones0;
        req = 1'b0; we = 1'b0; op = '0; addr = '0; wdata = '0; wpc = '0;
        rst_n = 1'b0;
        @(negedge clk);

        // T1: INIT sweep length, then every word reads zero
        reset_and_init("t1");
        for (int i = 0; i < DEPTH; i++)
            issue("t1_lw", 1'b0, 3'd0, 32'(i * 4), 32'h0, 32'h0, 1'b0, 1'b0);

        // T2 / T3: stores with lane merge, extending loads
        issue("t2_sw",    1'b1, 3'd0, 32'h8, 32'h1122_3344, 32'h0,         1'b0, 1'b0);
        issue("t2_lw",    1'b0, 3'd0, 32'h8, 32'h0,         32'h1122_3344, 1'b0, 1'b0);
        issue("t3_sb",    1'b1, 3'd3, 32'h9, 32'h0000_00AB, 32'h0,         1'b0, 1'b0);
        issue("t3_lw1",   1'b0, 3'd0, 32'h8, 32'h0,         32'h1122_AB44, 1'b0, 1'b0);
        issue("t3_lb",    1'b0, 3'd3, 32'h9, 32'h0,         32'hFFFF_FFAB, 1'b0, 1'b0);
        issue("t3_lbu",   1'b0, 3'd4, 32'h9, 32'h0,         32'h0000_00AB, 1'b0, 1'b0);
        issue("t3_sh",    1'b1, 3'd1, 32'hA, 32'h0000_8001, 32'h0,         1'b0, 1'b0);
        issue("t3_lw2",   1'b0, 3'd0, 32'h8, 32'h0,         32'h8001_AB44, 1'b0, 1'b0);
        issue("t3_lh",    1'b0, 3'd1, 32'hA, 32'h0,         32'hFFFF_8001, 1'b0, 1'b0);
        issue("t3_lhu",   1'b0, 3'd2, 32'hA, 32'h0,         32'h0000_8001, 1'b0, 1'b0);
        issue("t3_lb3",   1'b0, 3'd3, 32'hB, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0);
        issue("t3_lbu0",  1'b0, 3'd4, 32'h8, 32'h0,         32'h0000_0044, 1'b0, 1'b0);
        issue("t3_lh0",   1'b0, 3'd1, 32'h8, 32'h0,         32'hFFFF_AB44, 1'b0, 1'b0);
        issue("t3_sb0",   1'b1, 3'd4, 32'h8, 32'h1234_56CD, 32'h0,         1'b0, 1'b0);
        issue("t3_lw3",   1'b0, 3'd0, 32'h8, 32'h0,         32'h8001_ABCD, 1'b0, 1'b0);
        issue("t3_shu",   1'b1, 3'd2, 32'h8, 32'hFFFF_7777, 32'h0,         1'b0, 1'b0);
        issue("t3_lw4",   1'b0, 3'd0, 32'h8, 32'h0,         32'h8001_7777, 1'b0, 1'b0);

        // T4: alignment, opcode and range exceptions
        issue("t4_lw_mis",  1'b0, 3'd0, 32'h6,         32'h0,         32'h0, 1'b1, 1'b0);
        issue("t4_sh_mis",  1'b1, 3'd1, 32'h5,         32'h0000_BEEF, 32'h0, 1'b0, 1'b1);
        issue("t4_lw4",     1'b0, 3'd0, 32'h4,         32'h0,         32'h0, 1'b0, 1'b0);
        issue("t4_op7",     1'b0, 3'd7, 32'h8,         32'h0,         32'h0, 1'b1, 1'b0);
        issue("t4_op5_st",  1'b1, 3'd5, 32'h8,         32'h5555_5555, 32'h0, 1'b0, 1'b1);
        issue("t4_lw8",     1'b0, 3'd0, 32'h8,         32'h0,         32'h8001_7777, 1'b0, 1'b0);
        issue("t4_lw_top",  1'b0, 3'd0, 32'(DEPTH*4),  32'h0,         32'h0, 1'b1, 1'b0);
        issue("t4_lw_last", 1'b0, 3'd0, 32'(DEPTH*4-4),32'h0,         32'h0, 1'b0, 1'b0);
        issue("t4_lw_wrap", 1'b0, 3'd0, 32'hFFFF_FFFC, 32'h0,         32'h0, 1'b1, 1'b0);
        issue("t4_sb_top",  1'b1, 3'd3, 32'(DEPTH*4),  32'h0000_0011, 32'h0, 1'b0, 1'b1);
        issue("t4_lh_last", 1'b0, 3'd1, 32'(DEPTH*4-2),32'h0,         32'h0, 1'b0, 1'b0);

        // T5: reset during WAIT aborts the store; INIT clears everything
        wait_ready();
        req = 1'b1; we = 1'b1; op = 3'd0; addr = 32'h4; wdata = 32'hDEAD_BEEF; wpc = 32'h2000;
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t5_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        reset_and_init("t5");
        issue("t5_lw4", 1'b0, 3'd0, 32'h4, 32'h0, 32'h0, 1'b0, 1'b0);
        issue("t5_lw8", 1'b0, 3'd0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);

        // T6: req held high; only cycles with ready=1 are accepted
        for (int i = 0; i < 4; i++)
            issue("t6_sw", 1'b1, 3'd0, 32'(i * 4), 32'h100 + 32'(i), 32'h0, 1'b0, 1'b0);
        wait_ready();
        while (sb.size() != 0) @(negedge clk);
        dones0  = dones;
        accepts = 0;
        for (int k = 0; k < 20; k++) begin
            req = 1'b1; we = 1'b0; op = 3'd0; addr = 32'((k % 4) * 4); wdata = 32'h0;
            if (ready === 1'b1) begin
                exp_t e;
                e.name  = "t6_lw";
                e.rdata = 32'h100 + 32'(k % 4);
                e.adel  = 1'b0;
                e.ades  = 1'b0;
                e.due   = cyc + 1 + LAT + 1;
                sb.push_back(e);
                accepts++;
            end
            @(negedge clk);
        end
        req = 1'b0;

        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t6_done_per_accept", dones - dones0, accepts);
        check("drain_pending", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
